// File: rtl/lfsr_stream_checker_if.sv
// Stream bus between the keystream receiver front end and the LFSR checker.
// Handshake: din_valid qualifies din for exactly the cycle it is high; there is
// no ready because the checker accepts one bit every clock. clear_errs is a level
// sampled every cycle, whether or not din_valid is set. All outputs are registered.
interface lfsr_stream_checker_if #(
   parameter int CNT_W = 16
);
   logic             din_valid;
   logic             din;
   logic             clear_errs;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [15:0]      state_out;

   modport master (
      output din_valid, din, clear_errs,
      input  locked, err_pulse, err_count, state_out
   );

   modport slave (
      input  din_valid, din, clear_errs,
      output locked, err_pulse, err_count, state_out
   );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR keystream.
// SEARCH loads received bits into the history register until enough consecutive
// predictions match; LOCKED flywheels its own LFSR copy and counts mispredictions.
module lfsr_stream_checker #(
   parameter int LOCK_COUNT   = 32,
   parameter int UNLOCK_COUNT = 4,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lfsr_stream_checker_if.slave bus,
   output logic                 dbg_state_o
);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [7:0] LOCK_C   = 8'(LOCK_COUNT);
   localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_COUNT);

   state_t           state_q, state_d;
   logic [15:0]      r_q, r_d;
   logic [4:0]       fill_q, fill_d;
   logic [7:0]       match_q, match_d;
   logic [7:0]       miss_q, miss_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             pulse_q, pulse_d;

   logic pred, hit, filled, lockup, lock_now, unlock_now;

   assign pred   = ~(r_q[15] ^ r_q[14] ^ r_q[12] ^ r_q[3]);
   assign hit    = (bus.din == pred);
   assign filled = (fill_q == 5'd16);
   // All-ones is the XNOR lockup state: it predicts itself forever, so it must never count toward lock.
   assign lockup = (r_q == 16'hFFFF);

   assign lock_now   = bus.din_valid && (state_q == SEARCH) && filled && hit && !lockup
                       && ((match_q + 8'd1) == LOCK_C);
   assign unlock_now = bus.din_valid && (state_q == LOCKED) && !hit && (UNLOCK_C != 8'd0)
                       && ((miss_q + 8'd1) == UNLOCK_C);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SEARCH;
      else        state_q <= state_d;
   end

   // FSM next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SEARCH:  if (lock_now)   state_d = LOCKED;
         LOCKED:  if (unlock_now) state_d = SEARCH;
         default: state_d = SEARCH;
      endcase
   end

   // Per-state datapath updates: history shift, fill/match/miss counters, error accounting.
   always_comb begin
      r_d     = r_q;
      fill_d  = fill_q;
      match_d = match_q;
      miss_d  = miss_q;
      err_d   = err_q;
      pulse_d = 1'b0;
      if (bus.din_valid) begin
         case (state_q)
            SEARCH: begin
               r_d = {r_q[14:0], bus.din};
               if (!filled)             fill_d  = fill_q + 5'd1;
               else if (lockup || !hit) match_d = 8'd0;
               else                     match_d = match_q + 8'd1;
               if (lock_now)            miss_d  = 8'd0;
            end
            LOCKED: begin
               // Flywheel: the received bit is only compared, never loaded.
               r_d = {r_q[14:0], pred};
               if (!hit) begin
                  pulse_d = 1'b1;
                  if (err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
                  if (miss_q != 8'hFF)        miss_d = miss_q + 8'd1;
               end else begin
                  miss_d = 8'd0;
               end
               if (unlock_now) begin
                  fill_d  = 5'd0;
                  match_d = 8'd0;
               end
            end
            default: ;
         endcase
      end
      if (bus.clear_errs) err_d = '0;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q     <= 16'd0;
         fill_q  <= 5'd0;
         match_q <= 8'd0;
         miss_q  <= 8'd0;
         err_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         r_q     <= r_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         miss_q  <= miss_d;
         err_q   <= err_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.locked    = (state_q == LOCKED);
   assign bus.err_pulse = pulse_q;
   assign bus.err_count = err_q;
   assign bus.state_out = r_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: default instance for lock/error/unlock
// behaviour, a CNT_W=4 / UNLOCK_COUNT=0 instance for saturation and never-unlock.
module tb_lfsr_stream_checker;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0_n, rst1_n;
   logic dbg0, dbg1;

   lfsr_stream_checker_if #(.CNT_W(16)) if0 ();
   lfsr_stream_checker_if #(.CNT_W(4))  if1 ();

   lfsr_stream_checker #(.LOCK_COUNT(32), .UNLOCK_COUNT(4), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst0_n), .bus(if0.slave), .dbg_state_o(dbg0)
   );

   lfsr_stream_checker #(.LOCK_COUNT(32), .UNLOCK_COUNT(0), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst1_n), .bus(if1.slave), .dbg_state_o(dbg1)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------- reference generator ----------------
   logic [15:0] gen;

   task automatic next_gen(output logic b);
      b   = ~(gen[15] ^ gen[14] ^ gen[12] ^ gen[3]);
      gen = {gen[14:0], b};
   endtask

   // ---------------- driver tasks ----------------
   // Drive one cycle on instance sel, then return 1 time unit after the edge.
   task automatic send(input int sel, input logic v, input logic d, input logic clr);
      @(negedge clk);
      if (sel == 0) begin
         if0.din_valid = v; if0.din = d; if0.clear_errs = clr;
      end else begin
         if1.din_valid = v; if1.din = d; if1.clear_errs = clr;
      end
      @(posedge clk);
      #1;
      if0.din_valid = 1'b0; if0.clear_errs = 1'b0;
      if1.din_valid = 1'b0; if1.clear_errs = 1'b0;
   endtask

   task automatic send_gen(input int sel, input logic flip, input logic clr);
      logic b;
      next_gen(b);
      send(sel, 1'b1, b ^ flip, clr);
   endtask

   int pulses;
   logic seen_lock;

   initial begin
      if0.din_valid = 1'b0; if0.din = 1'b0; if0.clear_errs = 1'b0;
      if1.din_valid = 1'b0; if1.din = 1'b0; if1.clear_errs = 1'b0;
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      #12;
      check("rst_locked",    32'(if0.locked),    32'd0);
      check("rst_err_pulse", 32'(if0.err_pulse), 32'd0);
      check("rst_err_count", 32'(if0.err_count), 32'd0);
      check("rst_state_out", 32'(if0.state_out), 32'd0);
      @(negedge clk);
      rst0_n = 1'b1;

      // T1: continuous clean stream from seed ACE1
      gen = 16'hACE1;
      for (int i = 0; i < 47; i++) send_gen(0, 1'b0, 1'b0);
      check("t1_locked_before_48", 32'(if0.locked), 32'd0);
      send_gen(0, 1'b0, 1'b0);
      check("t1_locked_at_48", 32'(if0.locked), 32'd1);
      check("t1_state_tracks", 32'(if0.state_out), 32'(gen));
      pulses = 0;
      for (int i = 48; i < 10000; i++) begin
         send_gen(0, 1'b0, 1'b0);
         pulses += int'(if0.err_pulse);
      end
      check("t1_err_count", 32'(if0.err_count), 32'd0);
      check("t1_no_pulses", 32'(pulses), 32'd0);
      check("t1_still_locked", 32'(if0.locked), 32'd1);
      check("t1_state_end", 32'(if0.state_out), 32'(gen));

      // T2: mid-operation async reset, then gapped stream
      @(negedge clk);
      rst0_n = 1'b0;
      #1;
      check("t2_async_rst_locked", 32'(if0.locked), 32'd0);
      check("t2_async_rst_state",  32'(if0.state_out), 32'd0);
      @(negedge clk);
      rst0_n = 1'b1;
      gen = 16'hACE1;
      for (int i = 0; i < 47; i++) begin
         send_gen(0, 1'b0, 1'b0);
         send(0, 1'b0, 1'b1, 1'b0);
      end
      check("t2_locked_before_48", 32'(if0.locked), 32'd0);
      check("t2_idle_holds_state", 32'(if0.state_out), 32'(gen));
      send_gen(0, 1'b0, 1'b0);
      check("t2_locked_at_48", 32'(if0.locked), 32'd1);
      check("t2_err_count", 32'(if0.err_count), 32'd0);

      // T3: single flipped bit while locked
      send_gen(0, 1'b1, 1'b0);
      check("t3_pulse",  32'(if0.err_pulse), 32'd1);
      check("t3_count",  32'(if0.err_count), 32'd1);
      check("t3_locked", 32'(if0.locked),    32'd1);
      send_gen(0, 1'b0, 1'b0);
      check("t3_pulse_drops", 32'(if0.err_pulse), 32'd0);
      for (int i = 0; i < 20; i++) send_gen(0, 1'b0, 1'b0);
      check("t3_count_holds", 32'(if0.err_count), 32'd1);
      check("t3_flywheel",    32'(if0.state_out), 32'(gen));

      // T4: clear, four consecutive errors drop lock, then re-acquire
      send(0, 1'b0, 1'b0, 1'b1);
      check("t4_cleared", 32'(if0.err_count), 32'd0);
      for (int i = 0; i < 3; i++) send_gen(0, 1'b1, 1'b0);
      check("t4_locked_after_3", 32'(if0.locked), 32'd1);
      send_gen(0, 1'b1, 1'b0);
      check("t4_unlocked",  32'(if0.locked),    32'd0);
      check("t4_pulse",     32'(if0.err_pulse), 32'd1);
      check("t4_count",     32'(if0.err_count), 32'd4);
      check("t4_not_loaded", 32'(if0.state_out), 32'(gen));
      for (int i = 0; i < 47; i++) send_gen(0, 1'b0, 1'b0);
      check("t4_relock_before_48", 32'(if0.locked), 32'd0);
      send_gen(0, 1'b0, 1'b0);
      check("t4_relock_at_48", 32'(if0.locked),    32'd1);
      check("t4_count_held",   32'(if0.err_count), 32'd4);
      send_gen(0, 1'b1, 1'b1);
      check("t4_clear_wins",   32'(if0.err_count), 32'd0);
      check("t4_clear_pulse",  32'(if0.err_pulse), 32'd1);

      // T5: all-ones stream never locks
      @(negedge clk);
      rst0_n = 1'b0;
      @(negedge clk);
      rst0_n = 1'b1;
      seen_lock = 1'b0;
      for (int i = 0; i < 100; i++) begin
         send(0, 1'b1, 1'b1, 1'b0);
         seen_lock |= if0.locked;
      end
      check("t5_never_locked", 32'(seen_lock),     32'd0);
      check("t5_state_ones",   32'(if0.state_out), 32'hFFFF);
      check("t5_no_errors",    32'(if0.err_count), 32'd0);

      // T6: narrow counter saturates, UNLOCK_COUNT=0 keeps lock
      @(negedge clk);
      rst1_n = 1'b1;
      gen = 16'hACE1;
      for (int i = 0; i < 48; i++) send_gen(1, 1'b0, 1'b0);
      check("t6_locked", 32'(if1.locked), 32'd1);
      for (int i = 1; i <= 20; i++) exp_q.push_back((i > 15) ? 4'd15 : 4'(i));
      for (int i = 1; i <= 20; i++) begin
         send_gen(1, 1'b1, 1'b0);
         check($sformatf("t6_sat_%0d", i), 32'(if1.err_count), 32'(exp_q.pop_front()));
      end
      check("t6_still_locked", 32'(if1.locked),    32'd1);
      check("t6_flywheel",     32'(if1.state_out), 32'(gen));
      @(negedge clk);
      rst1_n = 1'b0;
      #1;
      check("t6_rst_locked", 32'(if1.locked),    32'd0);
      check("t6_rst_pulse",  32'(if1.err_pulse), 32'd0);
      check("t6_rst_count",  32'(if1.err_count), 32'd0);
      check("t6_rst_state",  32'(if1.state_out), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Receive-side checker for the 16-bit XNOR LFSR keystream generator. It consumes the generator's serial output one bit per valid cycle and self-synchronises to it without knowing the seed. Once synchronised it flywheels its own copy of the LFSR and counts bit errors. It sits at the far end of the keystream link and provides link-integrity and lock status to the top-level control logic.

## Interface
- LOCK_COUNT, 32: consecutive correct predictions required to declare lock (1..255)
- UNLOCK_COUNT, 4: consecutive mispredictions in LOCKED that drop lock; 0 = never drop lock
- CNT_W, 16: width of the error counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- din_valid  in  1  din carries a stream bit this cycle
- din  in  1  received stream bit (generator's newly shifted-in LSB)
- clear_errs  in  1  synchronous clear of err_count
- locked  out  1  checker is synchronised
- err_pulse  out  1  one-cycle pulse per mispredicted bit while LOCKED
- err_count  out  CNT_W  saturating count of mispredicted bits while LOCKED
- state_out  out  16  checker's current 16-bit history register

## Operation
- History register r[15:0]; r[0] is the most recent bit. Prediction: pred = ~(r[15]^r[14]^r[12]^r[3]).
- Cycles with din_valid=0 change nothing except the clear_errs effect and err_pulse returning to 0.
- FSM states: SEARCH (reset state) and LOCKED.
- SEARCH, on each valid bit:
  - r <= {r[14:0], din}.
  - fill_cnt increments up to 16.
  - While fill_cnt < 16, no comparison is made.
  - Once fill_cnt = 16, compare din against pred. Match: match_cnt++. Mismatch: match_cnt <= 0.
  - If r == 16'hFFFF (the XNOR lockup state), a match does not increment match_cnt, and match_cnt is cleared.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED and set miss_cnt <= 0.
- LOCKED, on each valid bit:
  - r <= {r[14:0], pred}. This is flywheel mode: the received bit is not loaded.
  - din != pred: err_pulse=1, err_count++ (saturating at 2^CNT_W-1), miss_cnt++.
  - din == pred: miss_cnt <= 0.
  - If UNLOCK_COUNT != 0 and miss_cnt reaches UNLOCK_COUNT: go to SEARCH and clear fill_cnt and match_cnt. r keeps its value and resumes loading din.
- Errors are counted only in LOCKED. Mispredictions in SEARCH are never counted.
- clear_errs has priority over an increment in the same cycle: err_count <= 0.
- err_count holds its value across lock loss. Only reset or clear_errs clears it.

## Timing
- Reset (rst_n low, asynchronous): FSM=SEARCH, r=0, fill_cnt=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0, state_out=0.
- All outputs are registered.
- state_out equals r.
- locked rises in the cycle after the valid bit that completes LOCK_COUNT matches.
  - For a clean stream: after valid bit number 16+LOCK_COUNT (48 by default).
- err_pulse is high for exactly the cycle after the erroneous valid bit.
- err_count updates in that same cycle.
- locked falls in the cycle after the UNLOCK_COUNT-th consecutive miss. err_pulse is also asserted for that miss.
- The bit that causes unlock is counted as an error and is not loaded into r.
- Reset asserted mid-operation returns the block to reset values immediately. Lock re-acquires from fill_cnt=0 after rst_n rises.
- Throughput: one bit per clock. din_valid may be gapped arbitrarily.

## Test plan
- Seed generator with 16'hACE1, stream continuous valid bits -> locked=1 after bit 48, err_count=0 over 10000 bits, state_out tracks generator register.
- Same stream with din_valid low every other cycle -> locked rises after 48th valid bit, err_count=0.
- While locked, flip one bit -> err_pulse high one cycle, err_count=1, locked stays 1, next bits predicted correctly.
- While locked, flip 4 consecutive bits -> err_count=4, locked falls after 4th; clean stream thereafter -> locked again after 48 further valid bits.
- Feed all-ones stream after reset -> locked never asserts; clear_errs with simultaneous error -> err_count=0.
- CNT_W=4, UNLOCK_COUNT=0, lock then feed inverted stream for 20 bits -> err_count saturates at 15, locked stays 1; assert rst_n low -> all outputs 0.
